seq_addsub: RTL and testbench

Parametrised, multi-cycle two's-complement add/subtract unit. It is the next generation of the team's 4-bit combinational add/subtract block. Operands of WIDTH bits are latched on a start handshake and processed CHUNK bits per clock, LSB chunk first, through a single CHUNK-bit ripple slice with a registered carry. The result and status flags are then presented in registered form. It sits between the operand-entry logic (switch/register front end) and the display/result path, and trades latency for a small adder footprint at large widths.

---
 rtl/seq_addsub.sv | 116 +++++++++++
 tb/tb_seq_addsub.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_addsub.sv
// Multi-cycle two's-complement add/subtract: WIDTH-bit operands are processed
// CHUNK bits per clock through one ripple slice with a registered carry.
//
// state | meaning
// IDLE  | waiting for start; operands, op and carry seed latched on start
// BUSY  | one CHUNK-bit slice step per cycle, LSB chunk first
// DONE  | single-cycle done pulse; result and flags already registered
module seq_addsub #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic             carry_q;
    logic [CW-1:0]    step_q;

    logic [CHUNK:0]   slice_sum;
    logic [CHUNK-1:0] sum_chunk;
    logic             slice_cout;
    logic             top_cin;
    logic [WIDTH-1:0] acc_next;

    // Operand registers shift right each step, so the active chunk is always at
    // the bottom; the carry into the slice's top bit is recovered from its sum.
    always_comb begin
        slice_sum  = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry_q};
        sum_chunk  = slice_sum[CHUNK-1:0];
        slice_cout = slice_sum[CHUNK];
        top_cin    = sum_chunk[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];
        acc_next   = (acc_q >> CHUNK) | (WIDTH'(sum_chunk) << (WIDTH - CHUNK));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            carry_q   <= 1'b0;
            step_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= A;
                        b_q     <= op ? ~B : B;
                        carry_q <= op;
                        acc_q   <= '0;
                        step_q  <= '0;
                        busy    <= 1'b1;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    a_q     <= a_q >> CHUNK;
                    b_q     <= b_q >> CHUNK;
                    carry_q <= slice_cout;
                    acc_q   <= acc_next;
                    step_q  <= step_q + 1'b1;
                    if (step_q == LAST_STEP) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        result    <= acc_next;
                        carry_out <= slice_cout;
                        overflow  <= top_cin ^ slice_cout;
                        zero      <= (acc_next == '0);
                        negative  <= acc_next[WIDTH-1];
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_addsub.sv
// Bench for seq_addsub: directed and random operations on the 8/2 build
// against an integer arithmetic model, plus a parameter sweep.
module tb_seq_addsub;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       start = 1'b0;
    logic       op = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy, done, carry_out, overflow, zero, negative;
    logic [7:0] result;

    logic        sw_start = 1'b0;
    logic        sw_op8 = 1'b0;
    logic        sw_op16 = 1'b1;
    logic [7:0]  sw_a8 = 8'h7F;
    logic [7:0]  sw_b8 = 8'h01;
    logic [15:0] sw_a16 = 16'h8000;
    logic [15:0] sw_b16 = 16'h0001;

    logic        c1_busy, c1_done, c1_c, c1_v, c1_z, c1_n;
    logic [7:0]  c1_r;
    logic        c8_busy, c8_done, c8_c, c8_v, c8_z, c8_n;
    logic [7:0]  c8_r;
    logic        w_busy, w_done, w_c, w_v, w_z, w_n;
    logic [15:0] w_r;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    seq_addsub #(.WIDTH(8), .CHUNK(2)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .A(a), .B(b),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out),
        .overflow(overflow), .zero(zero), .negative(negative)
    );

    seq_addsub #(.WIDTH(8), .CHUNK(1)) dut_c1 (
        .clk(clk), .reset_n(reset_n), .start(sw_start), .op(sw_op8), .A(sw_a8), .B(sw_b8),
        .busy(c1_busy), .done(c1_done), .result(c1_r), .carry_out(c1_c),
        .overflow(c1_v), .zero(c1_z), .negative(c1_n)
    );

    seq_addsub #(.WIDTH(8), .CHUNK(8)) dut_c8 (
        .clk(clk), .reset_n(reset_n), .start(sw_start), .op(sw_op8), .A(sw_a8), .B(sw_b8),
        .busy(c8_busy), .done(c8_done), .result(c8_r), .carry_out(c8_c),
        .overflow(c8_v), .zero(c8_z), .negative(c8_n)
    );

    seq_addsub #(.WIDTH(16), .CHUNK(4)) dut_w16 (
        .clk(clk), .reset_n(reset_n), .start(sw_start), .op(sw_op16), .A(sw_a16), .B(sw_b16),
        .busy(w_busy), .done(w_done), .result(w_r), .carry_out(w_c),
        .overflow(w_v), .zero(w_z), .negative(w_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Plain integer arithmetic: unsigned and signed readings of the operation.
    task automatic model(input int w, input logic [15:0] ai, input logic [15:0] bi,
                         input logic oi, output logic [15:0] r, output logic c,
                         output logic v, output logic z, output logic n);
        longint m, ua, ub, sa, sb, s, rs;
        m  = 1;
        m  = m << w;
        ua = longint'(ai);
        ub = longint'(bi);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        s  = oi ? ua - ub : ua + ub;
        rs = oi ? sa - sb : sa + sb;
        r  = 16'(((s % m) + m) % m);
        c  = oi ? (ua >= ub) : (ua + ub >= m);
        v  = (rs >= m / 2) || (rs < -(m / 2));
        z  = (r == 16'h0);
        n  = r[w-1];
    endtask

    task automatic run_op(input logic [7:0] ai, input logic [7:0] bi, input logic oi,
                          input bit disturb, input string tag);
        logic [15:0] er;
        logic ec, ev, ez, en;
        int cyc, done_cyc, busy_cnt;
        model(8, {8'h00, ai}, {8'h00, bi}, oi, er, ec, ev, ez, en);
        @(negedge clk);
        start = 1'b1; a = ai; b = bi; op = oi;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; done_cyc = -1; busy_cnt = 0;
        while (done_cyc < 0 && cyc <= 20) begin
            if (disturb && cyc == 2) begin
                start = 1'b1; a = ~ai; b = ai ^ bi ^ 8'h5A; op = ~oi;
            end
            if (disturb && cyc == 3) start = 1'b0;
            if (disturb && cyc == 5) start = 1'b1;
            if (busy) busy_cnt++;
            if (done) begin
                done_cyc = cyc;
                check({tag, " busy_with_done"}, busy, 1'b0);
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        check({tag, " done_cycle"}, done_cyc, 5);
        check({tag, " busy_cycles"}, busy_cnt, 4);
        check({tag, " result"}, result, er[7:0]);
        check({tag, " carry_out"}, carry_out, ec);
        check({tag, " overflow"}, overflow, ev);
        check({tag, " zero"}, zero, ez);
        check({tag, " negative"}, negative, en);
        @(negedge clk);
        start = 1'b0;
        check({tag, " idle_after"}, {busy, done}, 2'b00);
        check({tag, " result_held"}, result, er[7:0]);
    endtask

    initial begin
        logic [15:0] er;
        logic ec, ev, ez, en;
        int dones[$];
        int cyc, d1, d8, d16, b1, b8, b16;
        logic [7:0] ra, rb;

        #1 reset_n = 1'b0;
        #2;
        check("reset_outputs", {busy, done, result, carry_out, overflow, zero, negative}, '0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        run_op(8'h7F, 8'h01, 1'b0, 1'b0, "add_ovf");
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, "add_wrap");
        run_op(8'h03, 8'h04, 1'b1, 1'b0, "sub_borrow");
        run_op(8'h05, 8'h05, 1'b1, 1'b0, "sub_zero");
        run_op(8'h80, 8'h01, 1'b1, 1'b0, "sub_ovf");
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, "pre_reset");

        // Reset in the middle of an operation.
        @(negedge clk);
        start = 1'b1; a = 8'h12; b = 8'h34; op = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("midop_busy", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check("midop_reset_outputs", {busy, done, result, carry_out, overflow, zero, negative}, '0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("no_done_after_reset", {busy, done}, 2'b00);
        end
        run_op(8'h01, 8'h01, 1'b0, 1'b0, "rst_recover");

        run_op(8'h21, 8'h13, 1'b0, 1'b1, "disturb_add");
        run_op(8'h40, 8'hC5, 1'b1, 1'b1, "disturb_sub");

        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op(ra, rb, 1'($urandom), 1'b0, $sformatf("rand%0d", i));
        end

        // start held high: done every N+2 cycles.
        model(8, 16'h0096, 16'h0047, 1'b1, er, ec, ev, ez, en);
        @(negedge clk);
        start = 1'b1; a = 8'h96; b = 8'h47; op = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 17; c++) begin
            if (done) begin
                dones.push_back(c);
                check("b2b_result", result, er[7:0]);
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("b2b_done_count", dones.size(), 3);
        if (dones.size() == 3) begin
            check("b2b_first", dones[0], 5);
            check("b2b_period1", dones[1] - dones[0], 6);
            check("b2b_period2", dones[2] - dones[1], 6);
        end
        repeat (8) @(negedge clk);
        check("b2b_idle", {busy, done}, 2'b00);

        // Parameter sweep on sibling instances.
        @(negedge clk);
        sw_start = 1'b1;
        @(negedge clk);
        sw_start = 1'b0;
        d1 = -1; d8 = -1; d16 = -1; b1 = 0; b8 = 0; b16 = 0;
        for (cyc = 1; cyc <= 20; cyc++) begin
            if (c1_busy) b1++;
            if (c8_busy) b8++;
            if (w_busy) b16++;
            if (c1_done && d1 < 0) d1 = cyc;
            if (c8_done && d8 < 0) d8 = cyc;
            if (w_done && d16 < 0) d16 = cyc;
            @(negedge clk);
        end
        model(8, 16'h007F, 16'h0001, 1'b0, er, ec, ev, ez, en);
        check("c1_done_cycle", d1, 9);
        check("c1_busy_cycles", b1, 8);
        check("c1_result", {c1_r, c1_c, c1_v, c1_z, c1_n}, {er[7:0], ec, ev, ez, en});
        check("c8_done_cycle", d8, 2);
        check("c8_busy_cycles", b8, 1);
        check("c8_result", {c8_r, c8_c, c8_v, c8_z, c8_n}, {er[7:0], ec, ev, ez, en});
        model(16, 16'h8000, 16'h0001, 1'b1, er, ec, ev, ez, en);
        check("w16_done_cycle", d16, 5);
        check("w16_busy_cycles", b16, 4);
        check("w16_result", w_r, er);
        check("w16_flags", {w_c, w_v, w_z, w_n}, {ec, ev, ez, en});
        check("w16_expected", {er, ev, ec}, {16'h7FFF, 1'b1, 1'b1});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
